// File: rtl/ovl_fire_collector.sv
// Collects 3-bit fire vectors from a bank of OVL checkers: saturating failure counters,
// sticky first-fail capture and a round-robin valid/ready event stream.
// Optional feature macro: OVL_FIRE_TIMESTAMP_EN (per-event capture timestamps on evt_time).
module ovl_fire_collector #(
  parameter int num_checkers = 4,
  parameter int count_width  = 16,
  parameter bit report_cover = 1'b0,
  parameter int time_width   = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [num_checkers*3-1:0] fire_in,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [4:0]                evt_index,
  output logic [1:0]                evt_type,
  output logic [time_width-1:0]     evt_time,
  output logic [count_width-1:0]    err_count,
  output logic [count_width-1:0]    xchk_count,
  output logic [count_width-1:0]    drop_count,
  output logic                      first_valid,
  output logic [4:0]                first_index
);

  localparam int NB = num_checkers * 3;
  localparam int PW = 8;
  localparam int SW = count_width + 7;

  localparam logic [NB-1:0] A_MASK   = {num_checkers{3'b001}};
  localparam logic [NB-1:0] X_MASK   = {num_checkers{3'b010}};
  localparam logic [NB-1:0] CAP_MASK = report_cover ? {num_checkers{3'b111}} : {num_checkers{3'b011}};

  function automatic logic [6:0] popcount(input logic [NB-1:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < NB; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

  function automatic logic [count_width-1:0] sat_add(input logic [count_width-1:0] a,
                                                     input logic [6:0] b);
    logic [SW-1:0] s;
    s = {7'd0, a} + {{(SW-7){1'b0}}, b};
    return (s[SW-1:count_width] != 7'd0) ? {count_width{1'b1}} : s[count_width-1:0];
  endfunction

  logic [NB-1:0]          pending_q, pending_d;
  logic [PW-1:0]          rr_q, rr_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [4:0]             evt_index_q, evt_index_d;
  logic [1:0]             evt_type_q, evt_type_d;
  logic [count_width-1:0] err_count_q, err_count_d;
  logic [count_width-1:0] xchk_count_q, xchk_count_d;
  logic [count_width-1:0] drop_count_q, drop_count_d;
  logic                   first_valid_q, first_valid_d;
  logic [4:0]             first_index_q, first_index_d;

  logic [NB-1:0] cap_s, held_s, drop_vec_s, gnt_vec_s, a_vec_s, x_vec_s;
  logic [PW-1:0] lo_idx_s, hi_idx_s, gnt_idx_s;
  logic          lo_found_s, hi_found_s, load_s, do_grant_s, first_hit_s;
  logic [4:0]    gnt_k_s, first_k_s;
  logic [1:0]    gnt_t_s;

  // Round-robin pick: lowest pending index at or after rr_q, else lowest overall.
  always_comb begin
    lo_found_s = 1'b0;
    hi_found_s = 1'b0;
    lo_idx_s   = '0;
    hi_idx_s   = '0;
    for (int j = NB - 1; j >= 0; j--) begin
      lo_found_s = lo_found_s | pending_q[j];
      lo_idx_s   = pending_q[j] ? PW'(j) : lo_idx_s;
      hi_found_s = hi_found_s | (pending_q[j] & (PW'(j) >= rr_q));
      hi_idx_s   = (pending_q[j] && (PW'(j) >= rr_q)) ? PW'(j) : hi_idx_s;
    end
    load_s     = ~evt_valid_q | evt_ready;
    do_grant_s = load_s & lo_found_s & ~clear;
    gnt_idx_s  = hi_found_s ? hi_idx_s : lo_idx_s;
    gnt_vec_s  = '0;
    gnt_k_s    = 5'd0;
    gnt_t_s    = 2'd0;
    for (int j = 0; j < NB; j++) begin
      gnt_vec_s[j] = do_grant_s & (gnt_idx_s == PW'(j));
      gnt_k_s      = (gnt_idx_s == PW'(j)) ? 5'(j / 3) : gnt_k_s;
      gnt_t_s      = (gnt_idx_s == PW'(j)) ? 2'(j % 3) : gnt_t_s;
    end
  end

  // Capture, drop detection and lowest-index bit0 search for first-fail.
  always_comb begin
    cap_s       = enable ? (fire_in & CAP_MASK) : '0;
    a_vec_s     = enable ? (fire_in & A_MASK) : '0;
    x_vec_s     = enable ? (fire_in & X_MASK) : '0;
    held_s      = pending_q & ~gnt_vec_s;
    drop_vec_s  = cap_s & held_s;
    first_hit_s = |a_vec_s;
    first_k_s   = 5'd0;
    for (int k = num_checkers - 1; k >= 0; k--) begin
      first_k_s = fire_in[3*k] ? 5'(k) : first_k_s;
    end
  end

  // Next-state for queue, stream registers, counters and first-fail; clear wins.
  always_comb begin
    pending_d     = held_s | cap_s;
    rr_d          = rr_q;
    evt_valid_d   = load_s ? do_grant_s : evt_valid_q;
    evt_index_d   = do_grant_s ? gnt_k_s : evt_index_q;
    evt_type_d    = do_grant_s ? gnt_t_s : evt_type_q;
    err_count_d   = sat_add(err_count_q, popcount(a_vec_s));
    xchk_count_d  = sat_add(xchk_count_q, popcount(x_vec_s));
    drop_count_d  = sat_add(drop_count_q, popcount(drop_vec_s));
    first_valid_d = first_valid_q | first_hit_s;
    first_index_d = (first_hit_s & ~first_valid_q) ? first_k_s : first_index_q;
    if (do_grant_s) begin
      rr_d = (gnt_idx_s == PW'(NB - 1)) ? '0 : gnt_idx_s + PW'(1);
    end else begin
      rr_d = rr_q;
    end
    if (clear) begin
      pending_d     = '0;
      evt_valid_d   = 1'b0;
      err_count_d   = '0;
      xchk_count_d  = '0;
      drop_count_d  = '0;
      first_valid_d = 1'b0;
      first_index_d = 5'd0;
    end else begin
      pending_d = held_s | cap_s;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q     <= '0;
      rr_q          <= '0;
      evt_valid_q   <= 1'b0;
      evt_index_q   <= 5'd0;
      evt_type_q    <= 2'd0;
      err_count_q   <= '0;
      xchk_count_q  <= '0;
      drop_count_q  <= '0;
      first_valid_q <= 1'b0;
      first_index_q <= 5'd0;
    end else begin
      pending_q     <= pending_d;
      rr_q          <= rr_d;
      evt_valid_q   <= evt_valid_d;
      evt_index_q   <= evt_index_d;
      evt_type_q    <= evt_type_d;
      err_count_q   <= err_count_d;
      xchk_count_q  <= xchk_count_d;
      drop_count_q  <= drop_count_d;
      first_valid_q <= first_valid_d;
      first_index_q <= first_index_d;
    end
  end

`ifdef OVL_FIRE_TIMESTAMP_EN
  logic [time_width-1:0] time_q, time_d;
  logic [time_width-1:0] evt_time_q, evt_time_d, gnt_time_s;
  logic [time_width-1:0] ts_q [NB];
  logic [time_width-1:0] ts_d [NB];

  // Free-running clock counter; a bit's stamp is only written when it is newly queued.
  always_comb begin
    time_d     = time_q + time_width'(1'b1);
    gnt_time_s = '0;
    for (int j = 0; j < NB; j++) begin
      gnt_time_s = gnt_vec_s[j] ? ts_q[j] : gnt_time_s;
      ts_d[j]    = (cap_s[j] & ~held_s[j] & ~clear) ? time_q : ts_q[j];
    end
    evt_time_d = do_grant_s ? gnt_time_s : evt_time_q;
  end

  // Timestamp registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      time_q     <= '0;
      evt_time_q <= '0;
      for (int j = 0; j < NB; j++) ts_q[j] <= '0;
    end else begin
      time_q     <= time_d;
      evt_time_q <= evt_time_d;
      for (int j = 0; j < NB; j++) ts_q[j] <= ts_d[j];
    end
  end

  assign evt_time = evt_time_q;
`else
  assign evt_time = '0;
`endif

  assign evt_valid   = evt_valid_q;
  assign evt_index   = evt_index_q;
  assign evt_type    = evt_type_q;
  assign err_count   = err_count_q;
  assign xchk_count  = xchk_count_q;
  assign drop_count  = drop_count_q;
  assign first_valid = first_valid_q;
  assign first_index = first_index_q;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Self-checking bench for ovl_fire_collector: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_ovl_fire_collector;

  localparam int NC   = 4;
  localparam int CW   = 16;
  localparam int TW   = 32;
  localparam int NB   = NC * 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clock;
  logic reset, enable, clear, evt_ready;
  logic [NB-1:0] fire_in;
  logic evt_valid, first_valid;
  logic [4:0] evt_index, first_index;
  logic [1:0] evt_type;
  logic [TW-1:0] evt_time;
  logic [CW-1:0] err_count, xchk_count, drop_count;

  logic c_enable, c_clear, c_ready;
  logic [NB-1:0] c_fire;
  logic c_valid, c_first_valid;
  logic [4:0] c_index, c_first_index;
  logic [1:0] c_type;
  logic [TW-1:0] c_time;
  logic [CW-1:0] c_err, c_xchk, c_drop;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_pend [NB];
  logic [TW-1:0] m_ts [NB];
  int          m_rr, m_index, m_type, m_err, m_xchk, m_drop, m_fi;
  bit          m_valid, m_fv;
  logic [TW-1:0] m_time, m_etime;

  ovl_fire_collector #(.num_checkers(NC), .count_width(CW), .report_cover(1'b0), .time_width(TW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .fire_in(fire_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index), .evt_type(evt_type),
    .evt_time(evt_time), .err_count(err_count), .xchk_count(xchk_count), .drop_count(drop_count),
    .first_valid(first_valid), .first_index(first_index));

  ovl_fire_collector #(.num_checkers(NC), .count_width(CW), .report_cover(1'b1), .time_width(TW)) dut_c (
    .clock(clock), .reset(reset), .enable(c_enable), .clear(c_clear), .fire_in(c_fire),
    .evt_valid(c_valid), .evt_ready(c_ready), .evt_index(c_index), .evt_type(c_type),
    .evt_time(c_time), .err_count(c_err), .xchk_count(c_xchk), .drop_count(c_drop),
    .first_valid(c_first_valid), .first_index(c_first_index));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_pend[i] = 1'b0;
      m_ts[i]   = '0;
    end
    m_rr = 0; m_index = 0; m_type = 0; m_err = 0; m_xchk = 0; m_drop = 0; m_fi = 0;
    m_valid = 1'b0; m_fv = 1'b0; m_time = '0; m_etime = '0;
  endtask

  // One clock edge of the collector described by its rules, for the report_cover=0 instance.
  task automatic model_step(input bit en, input bit clr, input logic [NB-1:0] f, input bit rdy);
    int g, p, na, nx;
    if (clr) begin
      for (int i = 0; i < NB; i++) m_pend[i] = 1'b0;
      m_err = 0; m_xchk = 0; m_drop = 0; m_fv = 1'b0; m_fi = 0; m_valid = 1'b0;
      m_time = m_time + 1;
      return;
    end
    if (!m_valid || rdy) begin
      g = -1;
      for (int s = 0; s < NB; s++) begin
        p = (m_rr + s) % NB;
        if (g < 0 && m_pend[p]) g = p;
      end
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_index = g / 3; m_type = g % 3; m_etime = m_ts[g];
        m_rr = (g + 1) % NB; m_pend[g] = 1'b0;
      end
    end
    if (en) begin
      na = 0; nx = 0;
      for (int k = 0; k < NC; k++) begin
        for (int t = 0; t < 2; t++) begin
          if (f[3*k+t]) begin
            if (m_pend[3*k+t]) m_drop = m_drop + 1;
            else begin
              m_pend[3*k+t] = 1'b1;
              m_ts[3*k+t] = m_time;
            end
          end
        end
        if (f[3*k]) begin
          na = na + 1;
          if (!m_fv) begin m_fv = 1'b1; m_fi = k; end
        end
        if (f[3*k+1]) nx = nx + 1;
      end
      m_err  = (m_err + na > CMAX) ? CMAX : m_err + na;
      m_xchk = (m_xchk + nx > CMAX) ? CMAX : m_xchk + nx;
      m_drop = (m_drop > CMAX) ? CMAX : m_drop;
    end
    m_time = m_time + 1;
  endtask

  task automatic tick();
    model_step(enable, clear, fire_in, evt_ready);
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    model_reset();
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    fire_in = 12'h001; evt_ready = 1'b0;
    tick();
    fire_in = 12'h000;
    tick();
    checks++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid: got %0b want 1", evt_valid); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({evt_valid, evt_index, evt_type, first_valid, first_index} !== 14'd0 || evt_time !== 32'd0) begin
      errors++; $display("FAIL reset_async_stream: got v=%0b i=%0d t=%0d fv=%0b fi=%0d time=%0d want all 0",
                         evt_valid, evt_index, evt_type, first_valid, first_index, evt_time);
    end
    checks++;
    if (err_count !== 16'd0 || xchk_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL reset_async_counts: got %0d/%0d/%0d want 0/0/0", err_count, xchk_count, drop_count);
    end
    #2 reset = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: cycle %0d got %0b want 0", i, evt_valid); end
    end
  endtask

  task automatic test_single();
    fire_in = 12'h001; evt_ready = 1'b1;
    tick();
    fire_in = 12'h000;
    checks++;
    if (err_count !== 16'd1 || first_valid !== 1'b1 || first_index !== 5'd0 || evt_valid !== 1'b0) begin
      errors++; $display("FAIL single_capture: got err=%0d fv=%0b fi=%0d v=%0b want 1/1/0/0",
                         err_count, first_valid, first_index, evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_index !== 5'd0 || evt_type !== 2'd0) begin
      errors++; $display("FAIL single_record: got v=%0b i=%0d t=%0d want 1/0/0", evt_valid, evt_index, evt_type);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %0b want 0", evt_valid); end
  endtask

  task automatic test_burst();
    apply_reset();
    fire_in = 12'h249; evt_ready = 1'b0;
    tick();
    fire_in = 12'h000;
    checks++;
    if (err_count !== 16'd4 || first_valid !== 1'b1 || first_index !== 5'd0) begin
      errors++; $display("FAIL burst_counts: got err=%0d fv=%0b fi=%0d want 4/1/0", err_count, first_valid, first_index);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_index !== 5'd0 || evt_type !== 2'd0) begin
        errors++; $display("FAIL burst_stall_hold: cycle %0d got v=%0b i=%0d t=%0d want 1/0/0",
                           i, evt_valid, evt_index, evt_type);
      end
    end
    evt_ready = 1'b1;
    for (int r = 1; r < 4; r++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_index !== 5'(r) || evt_type !== 2'd0) begin
        errors++; $display("FAIL burst_order: got v=%0b i=%0d t=%0d want 1/%0d/0", evt_valid, evt_index, evt_type, r);
      end
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL burst_end: got %0b want 0", evt_valid); end
  endtask

  task automatic test_drop();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    evt_ready = 1'b0;
    fire_in = 12'h001;
    tick();
    fire_in = 12'h080;
    tick();
    tick();
    fire_in = 12'h000;
    checks++;
    if (xchk_count !== 16'd2 || drop_count !== 16'd1 || err_count !== 16'd1) begin
      errors++; $display("FAIL drop_counts: got x=%0d d=%0d e=%0d want 2/1/1", xchk_count, drop_count, err_count);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_index !== 5'd0) begin
      errors++; $display("FAIL drop_stalled: got v=%0b i=%0d want 1/0", evt_valid, evt_index);
    end
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_index !== 5'd2 || evt_type !== 2'd1) begin
      errors++; $display("FAIL drop_record: got v=%0b i=%0d t=%0d want 1/2/1", evt_valid, evt_index, evt_type);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL drop_single_record: got %0b want 0", evt_valid); end
  endtask

  task automatic test_cover();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    fire_in = 12'h924;
    tick();
    fire_in = 12'h000;
    tick();
    checks++;
    if (evt_valid !== 1'b0 || err_count !== 16'd0 || xchk_count !== 16'd0 || drop_count !== 16'd0 || first_valid !== 1'b0) begin
      errors++; $display("FAIL cover_ignored: got v=%0b e=%0d x=%0d d=%0d fv=%0b want all 0",
                         evt_valid, err_count, xchk_count, drop_count, first_valid);
    end
    c_enable = 1'b1; c_ready = 1'b0; c_fire = 12'h004;
    tick();
    c_fire = 12'h800;
    tick();
    c_fire = 12'h000;
    checks++;
    if (c_valid !== 1'b1 || c_index !== 5'd0 || c_type !== 2'd2) begin
      errors++; $display("FAIL cover_record0: got v=%0b i=%0d t=%0d want 1/0/2", c_valid, c_index, c_type);
    end
    checks++;
    if (c_err !== 16'd0 || c_xchk !== 16'd0 || c_first_valid !== 1'b0) begin
      errors++; $display("FAIL cover_counts: got e=%0d x=%0d fv=%0b want 0/0/0", c_err, c_xchk, c_first_valid);
    end
    c_ready = 1'b1;
    tick();
    checks++;
    if (c_valid !== 1'b1 || c_index !== 5'd3 || c_type !== 2'd2) begin
      errors++; $display("FAIL cover_record3: got v=%0b i=%0d t=%0d want 1/3/2", c_valid, c_index, c_type);
    end
    tick();
    checks++;
    if (c_valid !== 1'b0) begin errors++; $display("FAIL cover_drained: got %0b want 0", c_valid); end
    c_enable = 1'b0;
  endtask

  task automatic test_saturate();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    evt_ready = 1'b1;
    fire_in = 12'h249;
    for (int i = 0; i < 16383; i++) tick();
    fire_in = 12'h009;
    tick();
    checks++;
    if (err_count !== 16'hFFFE || xchk_count !== 16'd0) begin
      errors++; $display("FAIL sat_preset: got err=%h x=%0d want fffe/0", err_count, xchk_count);
    end
    checks++;
    if (drop_count !== m_drop[CW-1:0]) begin
      errors++; $display("FAIL sat_drops: got %0d want %0d", drop_count, m_drop);
    end
    fire_in = 12'h001;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_nowrap: step %0d got %h want ffff", i, err_count); end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (err_count !== 16'd0 || evt_valid !== 1'b0 || first_valid !== 1'b0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL sat_clear: got e=%0d v=%0b fv=%0b d=%0d want 0/0/0/0",
                         err_count, evt_valid, first_valid, drop_count);
    end
    fire_in = 12'h000;
    tick();
    checks++;
    if (err_count !== 16'd0 || evt_valid !== 1'b0) begin
      errors++; $display("FAIL sat_after_clear: got e=%0d v=%0b want 0/0", err_count, evt_valid);
    end
  endtask

  task automatic test_random();
    logic [TW-1:0] exp_time;
    for (int n = 0; n < 3000; n++) begin
      enable    = ($urandom % 4) != 0;
      clear     = ($urandom % 64) == 0;
      evt_ready = ($urandom % 3) != 0;
      fire_in   = NB'($urandom & $urandom);
      tick();
`ifdef OVL_FIRE_TIMESTAMP_EN
      exp_time = m_etime;
`else
      exp_time = '0;
`endif
      checks++;
      if (evt_valid !== m_valid) begin errors++; $display("FAIL rand_valid: n=%0d got %0b want %0b", n, evt_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (evt_index !== 5'(m_index) || evt_type !== 2'(m_type) || evt_time !== exp_time) begin
          errors++; $display("FAIL rand_record: n=%0d got i=%0d t=%0d time=%0d want i=%0d t=%0d time=%0d",
                             n, evt_index, evt_type, evt_time, m_index, m_type, exp_time);
        end
      end
      checks++;
      if (err_count !== CW'(m_err) || xchk_count !== CW'(m_xchk) || drop_count !== CW'(m_drop)) begin
        errors++; $display("FAIL rand_counts: n=%0d got e=%0d x=%0d d=%0d want e=%0d x=%0d d=%0d",
                           n, err_count, xchk_count, drop_count, m_err, m_xchk, m_drop);
      end
      checks++;
      if (first_valid !== m_fv || (m_fv && first_index !== 5'(m_fi))) begin
        errors++; $display("FAIL rand_first: n=%0d got fv=%0b fi=%0d want fv=%0b fi=%0d",
                           n, first_valid, first_index, m_fv, m_fi);
      end
    end
    enable = 1'b1; clear = 1'b0; fire_in = '0; evt_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; clear = 1'b0; evt_ready = 1'b1; fire_in = '0;
    c_enable = 1'b0; c_clear = 1'b0; c_ready = 1'b1; c_fire = '0;
    model_reset();
    @(posedge clock);
    #1;
    #4 reset = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_drop();
    test_cover();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
